cv_norm_shift: RTL and testbench

- Pipelined mantissa normalizer.
- Consumes the leading-zero count of a mantissa, left-shifts the mantissa so its MSB is set, and decrements the exponent by the shift amount.
- Clamps the shift so the exponent never drops below MIN_EXP, which produces a subnormal result.
- Sits after the adder/multiplier datapath in the FPU and feeds rounding. Two register stages with valid/ready handshake on both sides.

---
 rtl/cv_norm_shift.sv | 149 ++++++++++++++
 tb/tb_cv_norm_shift.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_norm_shift.sv
// Two-stage mantissa normalizer: left-justifies the mantissa using its leading-zero
// count and lowers the exponent to match, never taking the exponent below MIN_EXP.

module cv_lzc #(
    parameter int WIDTH = 24,
    parameter int MODE  = 1,
    parameter int CNT_W = 5
) (
    input  logic [WIDTH-1:0] in,
    output logic [CNT_W-1:0] cnt,
    output logic             empty
);
    // MODE=1 counts leading zeros from the MSB, MODE=0 counts trailing zeros.
    always_comb begin
        cnt   = '0;
        empty = 1'b1;
        if (MODE == 1) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in[i]) begin
                    cnt   = CNT_W'(WIDTH - 1 - i);
                    empty = 1'b0;
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in[i]) begin
                    cnt   = CNT_W'(i);
                    empty = 1'b0;
                end
            end
        end
    end
endmodule

module cv_norm_shift #(
    parameter int WIDTH     = 24,
    parameter int EXP_WIDTH = 10,
    parameter int MIN_EXP   = -126,
    parameter int TAG_WIDTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [WIDTH-1:0]            in_mant_i,
    input  logic signed [EXP_WIDTH-1:0] in_exp_i,
    input  logic [TAG_WIDTH-1:0]        in_tag_i,
    input  logic                        flush_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [WIDTH-1:0]            out_mant_o,
    output logic signed [EXP_WIDTH-1:0] out_exp_o,
    output logic                        out_zero_o,
    output logic                        out_sub_o,
    output logic [TAG_WIDTH-1:0]        out_tag_o
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic signed [EXP_WIDTH:0] MIN_X = (EXP_WIDTH + 1)'(MIN_EXP);

    logic                        s1_valid;
    logic [WIDTH-1:0]            s1_mant;
    logic signed [EXP_WIDTH-1:0] s1_exp;
    logic [TAG_WIDTH-1:0]        s1_tag;
    logic [CNT_W-1:0]            s1_lzc;
    logic                        s1_zero;
    logic signed [EXP_WIDTH:0]   s1_head;

    logic [CNT_W-1:0]            lzc_cnt;
    logic                        lzc_empty;
    logic signed [EXP_WIDTH:0]   head_in;

    logic                        s2_adv;
    logic                        s2_load;
    logic                        s1_adv;
    logic                        accept;

    logic signed [EXP_WIDTH:0]   lzc_x;
    logic signed [EXP_WIDTH:0]   shamt;
    logic                        sub_n;
    logic [WIDTH-1:0]            mant_n;
    logic signed [EXP_WIDTH-1:0] exp_n;

    cv_lzc #(.WIDTH(WIDTH), .MODE(1), .CNT_W(CNT_W)) u_lzc (
        .in    (in_mant_i),
        .cnt   (lzc_cnt),
        .empty (lzc_empty)
    );

    assign head_in = $signed({in_exp_i[EXP_WIDTH-1], in_exp_i}) - MIN_X;

    assign s2_adv     = out_valid_o && out_ready_i;
    assign s2_load    = !out_valid_o || s2_adv;
    assign s1_adv     = s1_valid && s2_load;
    assign in_ready_o = !s1_valid || s1_adv;
    assign accept     = in_valid_i && in_ready_o && !flush_i;

    // Shift is the smaller of the zero count and the room left above MIN_EXP.
    always_comb begin
        lzc_x = $signed({{(EXP_WIDTH + 1 - CNT_W){1'b0}}, s1_lzc});
        shamt = '0;
        if (!s1_zero && !s1_head[EXP_WIDTH] && (s1_head != '0)) begin
            shamt = (s1_head < lzc_x) ? s1_head : lzc_x;
        end
        sub_n  = !s1_zero && (s1_head < lzc_x);
        mant_n = s1_zero ? '0 : (s1_mant << shamt);
        exp_n  = s1_exp - shamt[EXP_WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid    <= 1'b0;
            s1_mant     <= '0;
            s1_exp      <= '0;
            s1_tag      <= '0;
            s1_lzc      <= '0;
            s1_zero     <= 1'b0;
            s1_head     <= '0;
            out_valid_o <= 1'b0;
            out_mant_o  <= '0;
            out_exp_o   <= '0;
            out_zero_o  <= 1'b0;
            out_sub_o   <= 1'b0;
            out_tag_o   <= '0;
        end else begin
            if (flush_i) begin
                s1_valid    <= 1'b0;
                out_valid_o <= 1'b0;
            end else begin
                if (in_ready_o) s1_valid <= in_valid_i;
                if (s2_load)    out_valid_o <= s1_valid;
            end
            if (accept) begin
                s1_mant <= in_mant_i;
                s1_exp  <= in_exp_i;
                s1_tag  <= in_tag_i;
                s1_lzc  <= lzc_cnt;
                s1_zero <= lzc_empty;
                s1_head <= head_in;
            end
            if (s1_adv && !flush_i) begin
                out_mant_o <= mant_n;
                out_exp_o  <= exp_n;
                out_zero_o <= s1_zero;
                out_sub_o  <= sub_n;
                out_tag_o  <= s1_tag;
            end
        end
    end
endmodule

// File: tb/tb_cv_norm_shift.sv
// Directed bench for cv_norm_shift (WIDTH=8) with a queue scoreboard fed by a
// bit-serial normalization model.

module tb_cv_norm_shift;
    localparam int W    = 8;
    localparam int EW   = 10;
    localparam int MINE = -126;
    localparam int TW   = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [W-1:0]         in_mant = '0;
    logic signed [EW-1:0] in_exp = '0;
    logic [TW-1:0]        in_tag = '0;
    logic                 flush = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [W-1:0]         out_mant;
    logic signed [EW-1:0] out_exp;
    logic                 out_zero;
    logic                 out_sub;
    logic [TW-1:0]        out_tag;

    typedef struct {
        logic [W-1:0]         mant;
        logic signed [EW-1:0] exp;
        logic                 zero;
        logic                 sub;
        logic [TW-1:0]        tag;
    } res_t;

    res_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    cv_norm_shift #(.WIDTH(W), .EXP_WIDTH(EW), .MIN_EXP(MINE), .TAG_WIDTH(TW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_mant_i   (in_mant),
        .in_exp_i    (in_exp),
        .in_tag_i    (in_tag),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_mant_o  (out_mant),
        .out_exp_o   (out_exp),
        .out_zero_o  (out_zero),
        .out_sub_o   (out_sub),
        .out_tag_o   (out_tag)
    );

    always #5 clk = ~clk;

    // Shift one bit at a time until the MSB is set or the exponent floor is hit.
    function automatic res_t model(input logic [W-1:0] m, input logic signed [EW-1:0] e,
                                   input logic [TW-1:0] t);
        res_t r;
        r.mant = m;
        r.exp  = e;
        r.tag  = t;
        r.zero = (m == '0);
        r.sub  = 1'b0;
        if (m == '0) return r;
        if (e < MINE) begin
            r.sub = 1'b1;
            return r;
        end
        while (!r.mant[W-1] && r.exp > MINE) begin
            r.mant = r.mant << 1;
            r.exp  = r.exp - 10'sd1;
        end
        r.sub = !r.mant[W-1];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] m, input int e, input int t);
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = EW'(e);
        in_tag   = TW'(t);
    endtask

    // Compare any handshaked output at the falling edge, then record acceptance.
    task automatic tick();
        res_t r;
        logic acc;
        @(negedge clk);
        if (out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                r = sb.pop_front();
                check("out_mant", out_mant, r.mant);
                check("out_exp",  out_exp,  r.exp);
                check("out_zero", out_zero, r.zero);
                check("out_sub",  out_sub,  r.sub);
                check("out_tag",  out_tag,  r.tag);
            end
        end
        acc = in_valid && in_ready && !flush && !rst;
        @(posedge clk);
        if (rst || flush) sb.delete();
        if (acc) sb.push_back(model(in_mant, in_exp, in_tag));
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    logic [W-1:0]         snap_mant;
    logic signed [EW-1:0] snap_exp;
    logic [TW-1:0]        snap_tag;

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready, 1);
        check("rst_out_mant",  out_mant, 0);
        check("rst_out_exp",   out_exp, 0);
        check("rst_out_zero",  out_zero, 0);
        check("rst_out_sub",   out_sub, 0);
        check("rst_out_tag",   out_tag, 0);

        drive(8'h13, 5, 3);
        tick();
        in_valid = 1'b0;
        check("lat_cycle1_valid", out_valid, 0);
        tick();
        check("lat_cycle2_valid", out_valid, 1);
        check("c1_mant", out_mant, 8'h98);
        check("c1_exp",  out_exp, 2);
        check("c1_zero", out_zero, 0);
        check("c1_sub",  out_sub, 0);
        check("c1_tag",  out_tag, 3);
        tick();

        drive(8'h01, -122, 1);
        tick();
        drive(8'h00, 7, 2);
        tick();
        in_valid = 1'b0;
        check("clamp_mant", out_mant, 8'h10);
        check("clamp_exp",  out_exp, -126);
        check("clamp_sub",  out_sub, 1);
        tick();
        check("zero_mant", out_mant, 0);
        check("zero_exp",  out_exp, 7);
        check("zero_flag", out_zero, 1);
        check("zero_sub",  out_sub, 0);
        drain();

        drive(8'h80, -126, 4);  tick();
        drive(8'h40, -126, 5);  tick();
        drive(8'h80, -130, 6);  tick();
        drive(8'h01, 200, 7);   tick();
        drive(8'h3C, -124, 8);  tick();
        drain();

        for (int t = 0; t < 8; t++) begin
            drive(8'(8'h01 << t) | 8'(t), 10 - 3 * t, t);
            check("stream_in_ready", in_ready, 1);
            tick();
        end
        drain();

        out_ready = 1'b0;
        drive(8'h21, 3, 10);
        tick();
        drive(8'h07, -120, 11);
        tick();
        drive(8'h55, 0, 12);
        check("bp_full_in_ready", in_ready, 0);
        snap_mant = out_mant;
        snap_exp  = out_exp;
        snap_tag  = out_tag;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_mant_stable", out_mant, snap_mant);
            check("bp_exp_stable", out_exp, snap_exp);
            check("bp_tag_stable", out_tag, snap_tag);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && in_valid; i++) begin
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        check("bp_third_accepted", in_valid, 0);
        drain();

        out_ready = 1'b0;
        drive(8'h11, 1, 13);
        tick();
        drive(8'h22, 2, 14);
        tick();
        drive(8'h33, 3, 15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("flush_no_output", out_valid, 0);

        drive(8'h05, 20, 5);  tick();
        drive(8'h0A, 21, 6);  tick();
        drive(8'h14, 22, 7);  tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_mant",  out_mant, 0);
        check("mrst_out_exp",   out_exp, 0);
        check("mrst_out_zero",  out_zero, 0);
        check("mrst_out_sub",   out_sub, 0);
        check("mrst_out_tag",   out_tag, 0);
        check("mrst_in_ready",  in_ready, 1);
        out_ready = 1'b1;
        drive(8'h13, 5, 9);
        tick();
        in_valid = 1'b0;
        tick();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_mant",  out_mant, 8'h98);
        check("post_rst_tag",   out_tag, 9);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
